// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the CPU load/store unit and a DMA engine.
// Define DMEM_ARB_RR_EN for round-robin contention; default is CPU priority.
module dmem_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [WIDTH-1:0] cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic             cpu_gnt,
  output logic             cpu_stall,
  output logic             cpu_rvalid,
  output logic [WIDTH-1:0] cpu_rdata,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic             dma_last,
  input  logic [WIDTH-1:0] dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_gnt,
  output logic             dma_rvalid,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata
);

  typedef enum logic {
    FREE = 1'b0,
    LOCK = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             last_winner_q, last_winner_d;
  logic             cpu_rvalid_q, cpu_rvalid_d;
  logic             dma_rvalid_q, dma_rvalid_d;
  logic [WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [WIDTH-1:0] dma_rdata_q, dma_rdata_d;
  logic             cpu_pri;
  logic             cpu_win;
  logic             dma_win;

  // Contention policy: who wins when both ask in FREE.
  always_comb begin
`ifdef DMEM_ARB_RR_EN
    cpu_pri = last_winner_q;
`else
    cpu_pri = 1'b1;
`endif
  end

  always_comb begin
    cpu_win = 1'b0;
    dma_win = 1'b0;
    case (state_q)
      FREE: begin
        cpu_win = cpu_req & (~dma_req | cpu_pri);
        dma_win = dma_req & ~cpu_win;
      end
      LOCK: begin
        dma_win = dma_req;
      end
      default: begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
      end
    endcase
    // Grants are combinational, so block them while reset is held.
    if (rst) begin
      cpu_win = 1'b0;
      dma_win = 1'b0;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_win) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE: begin
        if (dma_win && !dma_last) state_d = LOCK;
      end
      LOCK: begin
        if ((dma_win && dma_last) || !dma_req) state_d = FREE;
      end
      default: state_d = FREE;
    endcase
  end

  always_comb begin
    last_winner_d = last_winner_q;
    if (cpu_win)      last_winner_d = 1'b0;
    else if (dma_win) last_winner_d = 1'b1;
  end

  always_comb begin
    cpu_rvalid_d = cpu_win & ~cpu_we;
    dma_rvalid_d = dma_win & ~dma_we;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    if (cpu_rvalid_d) cpu_rdata_d = mem_rdata;
    if (dma_rvalid_d) dma_rdata_d = mem_rdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FREE;
      last_winner_q <= 1'b1;
      cpu_rvalid_q  <= 1'b0;
      dma_rvalid_q  <= 1'b0;
      cpu_rdata_q   <= '0;
      dma_rdata_q   <= '0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      cpu_rvalid_q  <= cpu_rvalid_d;
      dma_rvalid_q  <= dma_rvalid_d;
      cpu_rdata_q   <= cpu_rdata_d;
      dma_rdata_q   <= dma_rdata_d;
    end
  end

  assign cpu_gnt    = cpu_win;
  assign dma_gnt    = dma_win;
  assign cpu_stall  = cpu_req & ~cpu_win;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule
